// File: rtl/wptr_level_pkg.sv
// Shared constants and Gray/binary conversions for the FIFO write-pointer block.
// Functions operate on GRAY_MAXW bits; callers zero-extend and cast back.
package wptr_level_pkg;

  localparam int DEFAULT_ADDRSIZE    = 4;
  localparam int DEFAULT_AFULL_RESET = 0;
  localparam int GRAY_MAXW           = 32;

  function automatic logic [GRAY_MAXW-1:0] bin_to_gray(input logic [GRAY_MAXW-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [GRAY_MAXW-1:0] gray_to_bin(input logic [GRAY_MAXW-1:0] gray);
    logic [GRAY_MAXW-1:0] bin;
    bin[GRAY_MAXW-1] = gray[GRAY_MAXW-1];
    for (int i = GRAY_MAXW - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/wptr_level_gray2bin.sv
// Combinational Gray-to-binary decoder of parameterised width.
// Each binary bit is the XOR of all Gray bits at or above its position.
module gray2bin #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign bin[gi] = ^gray[WIDTH-1:gi];
  end

endmodule

// File: rtl/wptr_level.sv
// Async-FIFO write-side pointer, full/almost-full flags and fill level.
// Optional sticky overflow flag enabled by defining WPTR_LEVEL_OVF_EN.
module wptr_level
  import wptr_level_pkg::*;
#(
  parameter int ADDRSIZE    = DEFAULT_ADDRSIZE,
  parameter int AFULL_RESET = DEFAULT_AFULL_RESET
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic [ADDRSIZE:0]   afull_thresh,
  input  logic                wovf_clr,
  output logic [ADDRSIZE:0]   wptr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic                wfull,
  output logic                wafull,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                wovf
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] AFULL_DEF = PW'(AFULL_RESET);

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] wlevel_q, wlevel_d;
  logic          wfull_q, wfull_d;
  logic          wafull_q, wafull_d;
  logic          accept;
  logic [PW-1:0] rbin;
  logic [PW-1:0] thresh_eff;

  gray2bin #(
    .WIDTH(PW)
  ) u_rptr_g2b (
    .gray (wq2_rptr),
    .bin  (rbin)
  );

  // Flags and level are computed from the next pointer so they are exact on
  // the edge that accepts the write; the read side is seen only via wq2_rptr.
  always_comb begin
    accept     = winc & ~wfull_q;
    wbin_d     = wbin_q + PW'(accept);
    wptr_d     = PW'(bin_to_gray(GRAY_MAXW'(wbin_d)));
    wfull_d    = (wptr_d == {~wq2_rptr[PW-1:PW-2], wq2_rptr[PW-3:0]});
    wlevel_d   = wbin_d - rbin;
    thresh_eff = (afull_thresh != '0) ? afull_thresh : AFULL_DEF;
    wafull_d   = (thresh_eff != '0) && (wlevel_d >= thresh_eff);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
    end
  end

  assign wptr   = wptr_q;
  assign waddr  = wbin_q[ADDRSIZE-1:0];
  assign wfull  = wfull_q;
  assign wafull = wafull_q;
  assign wlevel = wlevel_q;

`ifdef WPTR_LEVEL_OVF_EN
  logic wovf_q, wovf_d;

  // A dropped write wins over a clear in the same cycle.
  always_comb begin
    wovf_d = wovf_q;
    if (wovf_clr) wovf_d = 1'b0;
    if (winc && wfull_q) wovf_d = 1'b1;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) wovf_q <= 1'b0;
    else         wovf_q <= wovf_d;
  end

  assign wovf = wovf_q;
`else
  logic unused_wovf_clr;
  assign unused_wovf_clr = wovf_clr;
  assign wovf            = 1'b0;
`endif

endmodule
